// File: rtl/bcd_counter_ctrl_pkg.sv
// rtl/bcd_counter_ctrl_pkg.sv - shared types and constants for the BCD count sequencer
package bcd_ctrl_pkg;
  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam bcd_digit_t BCD_MAX    = 4'd9;
  localparam bcd_digit_t BLANK_CODE = 4'hF;

  function automatic logic is_bcd(bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_counter_ctrl_if.sv
// rtl/bcd_counter_ctrl_if.sv - control and digit bundle between controller and its driver
interface bcd_counter_ctrl_if;
  import bcd_ctrl_pkg::*;

  logic       start;
  logic       stop;
  logic       up_down;
  logic       load;
  bcd_digit_t load_tens;
  bcd_digit_t load_units;
  bcd_digit_t tens;
  bcd_digit_t units;
  logic       running;
  logic       tc_pulse;

  modport master (
    output start, stop, up_down, load, load_tens, load_units,
    input  tens, units, running, tc_pulse
  );

  modport slave (
    input  start, stop, up_down, load, load_tens, load_units,
    output tens, units, running, tc_pulse
  );
endinterface

// File: rtl/bcd_counter_ctrl_tick_prescaler.sv
// rtl/bcd_counter_ctrl_tick_prescaler.sv - divides clk into a one-cycle step tick every PER enabled cycles
module tick_prescaler #(
  parameter int PER = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = (PER > 1) ? $clog2(PER) : 1;
  localparam logic [W-1:0] LAST = W'(PER - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/bcd_counter_ctrl.sv
// rtl/bcd_counter_ctrl.sv - two-digit BCD up/down count sequencer; BCD_BLANK_LEADING_ZERO_EN blanks a zero tens digit
module bcd_counter_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int WRAP    = 1
) (
  input logic               clk,
  input logic               rst,
  bcd_counter_ctrl_if.slave bus
);
  localparam int PER = CLK_HZ / TICK_HZ;

  state_t     state, state_nx;
  bcd_digit_t tens_q, units_q, tens_nx, units_nx;
  logic       tc_q, tc_nx, running_q;
  logic       tick, pre_clr;

  // Prescaler restarts on every load and on a fresh start, so the first step is a full period away.
  assign pre_clr = bus.load || (state == IDLE && bus.start && !bus.stop);

  tick_prescaler #(.PER(PER)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (state == RUN),
    .tick (tick)
  );

  always_comb begin
    state_nx = state;
    tens_nx  = tens_q;
    units_nx = units_q;
    tc_nx    = 1'b0;
    if (bus.load) begin
      if (is_bcd(bus.load_tens) && is_bcd(bus.load_units)) begin
        tens_nx  = bus.load_tens;
        units_nx = bus.load_units;
      end
      if (state == HALT) state_nx = IDLE;
    end else if (bus.stop) begin
      if (state == RUN) state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.start) state_nx = RUN;
        RUN: if (tick) begin
          if (bus.up_down) begin
            if (tens_q == BCD_MAX && units_q == BCD_MAX) begin
              tc_nx = 1'b1;
              if (WRAP != 0) begin
                tens_nx  = 4'd0;
                units_nx = 4'd0;
              end else begin
                state_nx = HALT;
              end
            end else begin
              if (units_q < BCD_MAX) begin
                units_nx = units_q + 4'd1;
              end else begin
                units_nx = 4'd0;
                tens_nx  = tens_q + 4'd1;
              end
              // Saturating mode halts as soon as a step lands on the limit.
              if (WRAP == 0 && tens_q == BCD_MAX && units_q == 4'd8) begin
                tc_nx    = 1'b1;
                state_nx = HALT;
              end
            end
          end else begin
            if (tens_q == 4'd0 && units_q == 4'd0) begin
              tc_nx = 1'b1;
              if (WRAP != 0) begin
                tens_nx  = BCD_MAX;
                units_nx = BCD_MAX;
              end else begin
                state_nx = HALT;
              end
            end else begin
              if (units_q != 4'd0) begin
                units_nx = units_q - 4'd1;
              end else begin
                units_nx = BCD_MAX;
                tens_nx  = tens_q - 4'd1;
              end
              if (WRAP == 0 && tens_q == 4'd0 && units_q == 4'd1) begin
                tc_nx    = 1'b1;
                state_nx = HALT;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tens_q    <= 4'd0;
      units_q   <= 4'd0;
      tc_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state     <= state_nx;
      tens_q    <= tens_nx;
      units_q   <= units_nx;
      tc_q      <= tc_nx;
      running_q <= (state_nx == RUN);
    end
  end

`ifdef BCD_BLANK_LEADING_ZERO_EN
  assign bus.tens = (tens_q == 4'd0) ? BLANK_CODE : tens_q;
`else
  assign bus.tens = tens_q;
`endif
  assign bus.units    = units_q;
  assign bus.running  = running_q;
  assign bus.tc_pulse = tc_q;
endmodule

// File: doc/bcd_counter_ctrl.md
Name: bcd_counter_ctrl

Overview:
Sequencer that owns a two-digit BCD count (00–99) and feeds the seven-segment decoder's tens/units inputs. It divides the system clock into a step tick and counts up or down on each tick. It supports start/stop/load control and flags terminal count. It sits directly upstream of the display decoder in the top level.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
TICK_HZ, 1, count step rate in Hz; prescale period PER = CLK_HZ/TICK_HZ (integer, ≥2)
WRAP, 1, 1 = wrap at limit (99→00 up, 00→99 down); 0 = saturate and halt at limit

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  level-sampled; begin/resume counting
stop  in  1  level-sampled; pause counting
up_down  in  1  1 = count up, 0 = count down; sampled at each tick
load  in  1  load load_tens/load_units
load_tens  in  4  BCD tens value to load
load_units  in  4  BCD units value to load
tens  out  4  BCD tens digit to decoder
units  out  4  BCD units digit to decoder
running  out  1  high while in RUN
tc_pulse  out  1  one-cycle pulse when a step reaches or hits the limit

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: tens=0, units=0, running=0, tc_pulse=0, prescaler=0, state=IDLE. Reset mid-run aborts immediately, with no tc_pulse.
- Priority in a single cycle: rst > load > stop > start.
- FSM states: IDLE, RUN, HALT.
  - IDLE: start → RUN.
  - RUN: stop → IDLE. Saturating limit reached (WRAP=0) → HALT.
  - HALT: load → IDLE. start is ignored. Leaves only via load or rst.
- Registered outputs. A transition requested in cycle N is visible in cycle N+1, including running.
- Prescaler:
  - Counts 0..PER-1 only in RUN and produces an internal tick at PER-1.
  - Cleared to 0 on entry to RUN from IDLE, on load, and on reset.
  - Holds its value in IDLE and HALT.
  - The first step occurs PER cycles after running rises.
- Step on tick, up direction:
  - units<9: units+1.
  - Otherwise units=0 and tens+1.
  - At 99: WRAP=1 gives 00 with tc_pulse. WRAP=0 holds 99 with tc_pulse and goes to HALT.
- Step on tick, down direction: mirror of up. Underflow at 00 gives 99 (WRAP=1), or holds 00 and goes to HALT (WRAP=0). tc_pulse fires in both cases.
- tc_pulse is high for exactly the cycle after the limit tick.
- Load:
  - Accepted in any state.
  - If load_tens>9 or load_units>9 the whole load is rejected: digits unchanged, but the state still follows the load transition.
  - A load cycle never steps, even if a tick coincides; the tick is dropped.
- Stop and start in the same cycle: stop wins.
- Digits are always valid BCD 0–9 on tens/units, except under the optional feature below.

Optional Feature:
Macro BCD_BLANK_LEADING_ZERO_EN.
- Defined: when the internal tens==0, the tens output is driven 4'hF. The decoder treats codes >9 as segments off, so the leading zero is blanked. Internal counting is unaffected.
- Undefined: tens output always equals the internal tens register.

Decomposition:
- Shared package bcd_ctrl_pkg:
  - state enum typedef (IDLE/RUN/HALT)
  - BCD_MAX digit constant (4'd9)
  - BLANK_CODE constant (4'hF)
  - bcd_digit_t typedef (logic [3:0])
- One natural sub-module: tick_prescaler. Parameterised by PER, with clear and enable inputs and a tick output.
- Digit arithmetic and the FSM stay in bcd_counter_ctrl.

Test Plan:
All scenarios use CLK_HZ=10, TICK_HZ=1 (PER=10).
- Reset then start high for 1 cycle → running=1 next cycle; units=1 exactly 10 cycles after running rose, and 2 after 20.
- Load 9/8, start, up, WRAP=1 → after 1 tick 99, after 2 ticks 00 with tc_pulse high for 1 cycle.
- WRAP=0, load 0/1, down, start → step to 00, tc_pulse once, running=0, state HALT. A further start is ignored; load 5/5 → IDLE, digits 55.
- Load tens=4'hA, units=3 while counting 42 → digits stay 42; prescaler cleared (next step 10 cycles later).
- Start and stop asserted together in RUN → IDLE, running=0, digits frozen. rst asserted mid-run at 37 → 00, running=0, no tc_pulse.
- With BCD_BLANK_LEADING_ZERO_EN defined: load 0/7 → tens output 4'hF, units 7. Count up to 10 → tens output 1.
